// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the multicycle control FSM: states, opcodes, ALUop and mux selects.
package multicycle_control_pkg;

    localparam int unsigned STATE_W = 4;
    localparam int unsigned OP_W    = 6;
    localparam int unsigned ALUOP_W = 2;
    localparam int unsigned SEL_W   = 2;

    typedef enum logic [STATE_W-1:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECUTE = 4'd6,
        S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JUMP    = 4'd11
    } state_t;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OP_W-1:0] OP_J     = 6'b000010;

    // Shared with the downstream ALU-control decoder.
    localparam logic [ALUOP_W-1:0] ALUOP_ADD   = 2'b00;
    localparam logic [ALUOP_W-1:0] ALUOP_SUB   = 2'b01;
    localparam logic [ALUOP_W-1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [SEL_W-1:0] SRCB_REG   = 2'b00;
    localparam logic [SEL_W-1:0] SRCB_FOUR  = 2'b01;
    localparam logic [SEL_W-1:0] SRCB_IMM   = 2'b10;
    localparam logic [SEL_W-1:0] SRCB_BROFF = 2'b11;

    localparam logic [SEL_W-1:0] PCSRC_ALU    = 2'b00;
    localparam logic [SEL_W-1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [SEL_W-1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic [ALUOP_W-1:0] aluop;
        logic               alusrca;
        logic [SEL_W-1:0]   alusrcb;
        logic [SEL_W-1:0]   pcsrc;
        logic               iord;
        logic               regdst;
        logic               memtoreg;
        logic               branch;
        logic               pcwrite;
        logic               irwrite;
        logic               regwrite;
        logic               memwrite;
    } ctrl_t;

endpackage

// File: rtl/multicycle_outdec.sv
// Moore output decode: maps the registered state (and mem_ready for fetch) to the control word.
module multicycle_outdec
    import multicycle_control_pkg::*;
(
    input  state_t st,
    input  logic   mem_ready,
    output ctrl_t  ctrl_c
);

    always_comb begin
        ctrl_c         = '0;
        ctrl_c.aluop   = ALUOP_ADD;
        ctrl_c.alusrcb = SRCB_REG;
        ctrl_c.pcsrc   = PCSRC_ALU;
        case (st)
            S_FETCH: begin
                ctrl_c.alusrcb = SRCB_FOUR;
                ctrl_c.irwrite = mem_ready;
                ctrl_c.pcwrite = mem_ready;
            end
            S_DECODE: ctrl_c.alusrcb = SRCB_BROFF;
            S_MEMADR, S_ADDIEX: begin
                ctrl_c.alusrca = 1'b1;
                ctrl_c.alusrcb = SRCB_IMM;
            end
            S_MEMRD: ctrl_c.iord = 1'b1;
            S_MEMWB: begin
                ctrl_c.memtoreg = 1'b1;
                ctrl_c.regwrite = 1'b1;
            end
            S_MEMWR: begin
                ctrl_c.iord     = 1'b1;
                ctrl_c.memwrite = 1'b1;
            end
            S_EXECUTE: begin
                ctrl_c.alusrca = 1'b1;
                ctrl_c.aluop   = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                ctrl_c.regdst   = 1'b1;
                ctrl_c.regwrite = 1'b1;
            end
            S_BRANCH: begin
                ctrl_c.alusrca = 1'b1;
                ctrl_c.aluop   = ALUOP_SUB;
                ctrl_c.pcsrc   = PCSRC_ALUOUT;
                ctrl_c.branch  = 1'b1;
            end
            S_ADDIWB: ctrl_c.regwrite = 1'b1;
            S_JUMP: begin
                ctrl_c.pcsrc   = PCSRC_JUMP;
                ctrl_c.pcwrite = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS-style control FSM: state register, next-state logic and datapath control outputs.
module multicycle_control
    import multicycle_control_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic [OP_W-1:0]     op,
    input  logic                mem_ready,
    output logic [ALUOP_W-1:0]  ALUop,
    output logic                ALUSrcA,
    output logic [SEL_W-1:0]    ALUSrcB,
    output logic [SEL_W-1:0]    PCSrc,
    output logic                IorD,
    output logic                RegDst,
    output logic                MemtoReg,
    output logic                Branch,
    output logic                PCWrite,
    output logic                IRWrite,
    output logic                RegWrite,
    output logic                MemWrite,
    output logic                illegal_op,
    output logic [STATE_W-1:0]  state
);

    state_t state_q;
    state_t state_d;
    ctrl_t  ctrl_c;
    logic   illegal_c;

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= S_FETCH;
        else        state_q <= state_d;
    end

    // op is only consulted in DECODE and MEMADR.
    always_comb begin
        state_d   = S_FETCH;
        illegal_c = 1'b0;
        case (state_q)
            S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXECUTE;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JUMP;
                    default:      illegal_c = 1'b1;
                endcase
            end
            S_MEMADR: begin
                if (op == OP_LW)      state_d = S_MEMRD;
                else if (op == OP_SW) state_d = S_MEMWR;
            end
            S_MEMRD:   state_d = mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWR:   state_d = mem_ready ? S_FETCH : S_MEMWR;
            S_EXECUTE: state_d = S_ALUWB;
            S_ADDIEX:  state_d = S_ADDIWB;
            default:   state_d = S_FETCH;
        endcase
    end

    multicycle_outdec u_outdec (
        .st        (state_q),
        .mem_ready (mem_ready),
        .ctrl_c    (ctrl_c)
    );

    assign ALUop      = ctrl_c.aluop;
    assign ALUSrcA    = ctrl_c.alusrca;
    assign ALUSrcB    = ctrl_c.alusrcb;
    assign PCSrc      = ctrl_c.pcsrc;
    assign IorD       = ctrl_c.iord;
    assign RegDst     = ctrl_c.regdst;
    assign MemtoReg   = ctrl_c.memtoreg;
    assign Branch     = ctrl_c.branch;
    // Write enables are held off for the whole reset assertion, not just after the edge.
    assign PCWrite    = ctrl_c.pcwrite  & rst_n;
    assign IRWrite    = ctrl_c.irwrite  & rst_n;
    assign RegWrite   = ctrl_c.regwrite & rst_n;
    assign MemWrite   = ctrl_c.memwrite & rst_n;
    assign illegal_op = illegal_c;
    assign state      = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: walks each instruction class cycle by cycle.
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] op;
    logic       mem_ready;
    logic [1:0] ALUop;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] PCSrc;
    logic       IorD, RegDst, MemtoReg, Branch;
    logic       PCWrite, IRWrite, RegWrite, MemWrite;
    logic       illegal_op;
    logic [3:0] state;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    multicycle_control dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .op         (op),
        .mem_ready  (mem_ready),
        .ALUop      (ALUop),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .PCSrc      (PCSrc),
        .IorD       (IorD),
        .RegDst     (RegDst),
        .MemtoReg   (MemtoReg),
        .Branch     (Branch),
        .PCWrite    (PCWrite),
        .IRWrite    (IRWrite),
        .RegWrite   (RegWrite),
        .MemWrite   (MemWrite),
        .illegal_op (illegal_op),
        .state      (state)
    );

    task automatic test_reset();
        logic [3:0] we;
        rst_n = 1'b0; mem_ready = 1'b1; op = 6'b000000;
        repeat (2) begin
            @(negedge clk);
            we = {PCWrite, IRWrite, RegWrite, MemWrite};
            n_cmp++;
            if (state !== 4'd0) begin
                n_err++; $display("FAIL reset_state got %0d want 0", state);
            end
            n_cmp++;
            if (we !== 4'b0000) begin
                n_err++; $display("FAIL reset_enables got %b want 0000", we);
            end
        end
        rst_n = 1'b1;
        #1;
        n_cmp++;
        if ({PCWrite, IRWrite, state} !== {2'b11, 4'd0}) begin
            n_err++; $display("FAIL reset_release pcw=%b irw=%b state=%0d want 1 1 0", PCWrite, IRWrite, state);
        end
    endtask

    task automatic test_lw();
        logic [3:0] seq [0:4];
        seq = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4};
        op = 6'b100011; mem_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            n_cmp++;
            if (state !== seq[i]) begin
                n_err++; $display("FAIL lw_state cyc%0d got %0d want %0d", i, state, seq[i]);
            end
            n_cmp++;
            if ({RegWrite, MemtoReg} !== {2{seq[i] == 4'd4}}) begin
                n_err++; $display("FAIL lw_wb cyc%0d regwrite=%b memtoreg=%b want %b", i, RegWrite, MemtoReg, seq[i] == 4'd4);
            end
            @(negedge clk);
        end
        #1;
        n_cmp++;
        if (state !== 4'd0) begin
            n_err++; $display("FAIL lw_end got %0d want 0", state);
        end
    endtask

    task automatic test_sw_wait();
        logic [3:0] seq [0:2];
        int mw_cycles;
        seq = '{4'd0, 4'd1, 4'd2};
        mw_cycles = 0;
        op = 6'b101011; mem_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_cmp++;
            if (state !== seq[i]) begin
                n_err++; $display("FAIL sw_state cyc%0d got %0d want %0d", i, state, seq[i]);
            end
            @(negedge clk);
        end
        for (int w = 0; w < 4; w++) begin
            mem_ready = (w == 3);
            #1;
            n_cmp++;
            if ({state, IorD, MemWrite} !== {4'd5, 2'b11}) begin
                n_err++; $display("FAIL sw_memwr w%0d state=%0d iord=%b memwrite=%b want 5 1 1", w, state, IorD, MemWrite);
            end
            if (MemWrite === 1'b1) mw_cycles++;
            @(negedge clk);
        end
        #1;
        n_cmp++;
        if (mw_cycles != 4) begin
            n_err++; $display("FAIL sw_memwrite_cycles got %0d want 4", mw_cycles);
        end
        n_cmp++;
        if ({state, MemWrite} !== {4'd0, 1'b0}) begin
            n_err++; $display("FAIL sw_end state=%0d memwrite=%b want 0 0", state, MemWrite);
        end
    endtask

    task automatic test_rtype();
        logic [3:0] seq [0:3];
        seq = '{4'd0, 4'd1, 4'd6, 4'd7};
        op = 6'b000000; mem_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            // op changes after DECODE must not disturb the sequence
            if (i == 2) op = 6'b111111;
            if (i == 3) op = 6'b000100;
            #1;
            n_cmp++;
            if (state !== seq[i]) begin
                n_err++; $display("FAIL rtype_state cyc%0d got %0d want %0d", i, state, seq[i]);
            end
            n_cmp++;
            if (ALUop !== ((seq[i] == 4'd6) ? 2'b10 : 2'b00)) begin
                n_err++; $display("FAIL rtype_aluop cyc%0d got %b", i, ALUop);
            end
            n_cmp++;
            if ({RegDst, RegWrite} !== {2{seq[i] == 4'd7}}) begin
                n_err++; $display("FAIL rtype_wb cyc%0d regdst=%b regwrite=%b", i, RegDst, RegWrite);
            end
            @(negedge clk);
        end
        #1;
        n_cmp++;
        if (state !== 4'd0) begin
            n_err++; $display("FAIL rtype_end got %0d want 0", state);
        end
    endtask

    task automatic test_short_ops();
        logic [5:0] ops  [0:2];
        logic [3:0] last [0:2];
        int         len  [0:2];
        ops  = '{6'b000100, 6'b000010, 6'b001000};
        last = '{4'd8, 4'd11, 4'd10};
        len  = '{3, 3, 4};
        mem_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            op = ops[k];
            for (int i = 0; i < len[k]; i++) begin
                @(negedge clk);
            end
            // back at the last state of the instruction? no: len cycles later we're in FETCH
            #1;
            n_cmp++;
            if (state !== 4'd0) begin
                n_err++; $display("FAIL short_len op=%b got state %0d want 0", ops[k], state);
            end
        end
        // Re-run each one and check the final execute state's outputs
        for (int k = 0; k < 3; k++) begin
            op = ops[k];
            for (int i = 0; i < len[k] - 1; i++) @(negedge clk);
            #1;
            n_cmp++;
            if (state !== last[k]) begin
                n_err++; $display("FAIL short_last op=%b got %0d want %0d", ops[k], state, last[k]);
            end
            case (k)
                0: begin
                    n_cmp++;
                    if ({Branch, PCSrc, ALUop, ALUSrcA, PCWrite} !== {1'b1, 2'b01, 2'b01, 1'b1, 1'b0}) begin
                        n_err++; $display("FAIL beq_outputs br=%b pcsrc=%b aluop=%b srca=%b pcw=%b", Branch, PCSrc, ALUop, ALUSrcA, PCWrite);
                    end
                end
                1: begin
                    n_cmp++;
                    if ({PCWrite, PCSrc, Branch} !== {1'b1, 2'b10, 1'b0}) begin
                        n_err++; $display("FAIL j_outputs pcw=%b pcsrc=%b br=%b", PCWrite, PCSrc, Branch);
                    end
                end
                default: begin
                    n_cmp++;
                    if ({RegWrite, RegDst, MemtoReg} !== 3'b100) begin
                        n_err++; $display("FAIL addi_wb rw=%b rd=%b m2r=%b want 1 0 0", RegWrite, RegDst, MemtoReg);
                    end
                end
            endcase
            @(negedge clk);
        end
    endtask

    task automatic test_illegal();
        op = 6'b111111; mem_ready = 1'b1;
        #1;
        n_cmp++;
        if ({state, illegal_op} !== {4'd0, 1'b0}) begin
            n_err++; $display("FAIL illegal_fetch state=%0d illegal=%b want 0 0", state, illegal_op);
        end
        @(negedge clk);
        #1;
        n_cmp++;
        if ({state, illegal_op} !== {4'd1, 1'b1}) begin
            n_err++; $display("FAIL illegal_decode state=%0d illegal=%b want 1 1", state, illegal_op);
        end
        n_cmp++;
        if ({PCWrite, IRWrite, RegWrite, MemWrite} !== 4'b0000) begin
            n_err++; $display("FAIL illegal_enables got %b want 0000", {PCWrite, IRWrite, RegWrite, MemWrite});
        end
        @(negedge clk);
        #1;
        n_cmp++;
        if ({state, illegal_op} !== {4'd0, 1'b0}) begin
            n_err++; $display("FAIL illegal_next state=%0d illegal=%b want 0 0", state, illegal_op);
        end
    endtask

    task automatic test_reset_midwait();
        op = 6'b100011; mem_ready = 1'b1;
        repeat (2) @(negedge clk);
        mem_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            #1;
            n_cmp++;
            if ({state, RegWrite, IorD} !== {4'd3, 1'b0, 1'b1}) begin
                n_err++; $display("FAIL midwait_memrd cyc%0d state=%0d rw=%b iord=%b want 3 0 1", i, state, RegWrite, IorD);
            end
        end
        rst_n = 1'b0;
        @(negedge clk);
        #1;
        n_cmp++;
        if ({state, RegWrite} !== {4'd0, 1'b0}) begin
            n_err++; $display("FAIL midwait_abort state=%0d rw=%b want 0 0", state, RegWrite);
        end
        mem_ready = 1'b1;
        #1;
        n_cmp++;
        if ({PCWrite, IRWrite} !== 2'b00) begin
            n_err++; $display("FAIL midwait_forced pcw=%b irw=%b want 0 0", PCWrite, IRWrite);
        end
        rst_n = 1'b1;
        #1;
        n_cmp++;
        if ({state, PCWrite, IRWrite, RegWrite} !== {4'd0, 3'b110}) begin
            n_err++; $display("FAIL midwait_release state=%0d pcw=%b irw=%b rw=%b want 0 1 1 0", state, PCWrite, IRWrite, RegWrite);
        end
    endtask

    initial begin
        test_reset();
        test_lw();
        test_sw_wait();
        test_rtype();
        test_short_ops();
        test_illegal();
        test_reset_midwait();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 The port clk SHALL be an input, 1 bit wide, and be the single clock; all state SHALL update on its rising edge.
REQ-002 The port rst_n SHALL be an input, 1 bit wide, and be the reset; it is synchronous and active-low.
REQ-003 The port op SHALL be an input, 6 bits wide, carrying the opcode field of the instruction register.
REQ-004 The port mem_ready SHALL be an input, 1 bit wide; when high, the current memory access completes this cycle.
REQ-005 The port ALUop SHALL be an output, 2 bits wide, and feed the downstream ALU-control decoder: 00 add, 01 sub, 10 use funct.
REQ-006 The ports ALUSrcA (1 bit), ALUSrcB (2 bits) and PCSrc (2 bits) SHALL be outputs and drive the datapath mux selects.
REQ-007 The ports IorD, RegDst, MemtoReg and Branch SHALL be outputs, 1 bit each, and drive the datapath selects.
REQ-008 The ports PCWrite, IRWrite, RegWrite and MemWrite SHALL be outputs, 1 bit each, and act as write enables.
REQ-009 The port illegal_op SHALL be an output, 1 bit wide, and flag an unsupported opcode.
REQ-010 The port state SHALL be an output, 4 bits wide, and expose the current FSM state for debug.

Function
REQ-011 The block SHALL be a Moore FSM; all outputs SHALL decode from the registered state, and mem_ready SHALL gate only the enables stated below.
REQ-012 The supported opcodes SHALL be R-type 000000, lw 100011, sw 101011, beq 000100, addi 001000 and j 000010.
REQ-013 Any output not listed for a state SHALL be 0.
REQ-014 The FETCH state (0) SHALL drive ALUSrcB=01 and ALUop=00, with IRWrite=PCWrite=mem_ready; it goes to DECODE when mem_ready is high and stays in FETCH otherwise.
REQ-015 The DECODE state (1) SHALL drive ALUSrcB=11 and ALUop=00.
- Next state by op: lw/sw go to MEMADR, R-type to EXECUTE, beq to BRANCH, addi to ADDIEX, j to JUMP.
- Any other op goes to FETCH with illegal_op=1 for this single cycle.
REQ-016 The MEMADR state (2) SHALL drive ALUSrcA=1, ALUSrcB=10 and ALUop=00; it goes to MEMRD for lw and to MEMWR for sw.
REQ-017 The MEMRD state (3) SHALL drive IorD=1; it goes to MEMWB when mem_ready is high and holds otherwise.
REQ-018 The MEMWB state (4) SHALL drive MemtoReg=1 and RegWrite=1, then go to FETCH.
REQ-019 The MEMWR state (5) SHALL drive IorD=1 and MemWrite=1 until the cycle mem_ready is high, then go to FETCH.
REQ-020 The EXECUTE state (6) SHALL drive ALUSrcA=1, ALUSrcB=00 and ALUop=10, then go to ALUWB.
REQ-021 The ALUWB state (7) SHALL drive RegDst=1 and RegWrite=1, then go to FETCH.
REQ-022 The BRANCH state (8) SHALL drive ALUSrcA=1, ALUop=01, PCSrc=01 and Branch=1, then go to FETCH.
REQ-023 The ADDIEX state (9) SHALL drive ALUSrcA=1, ALUSrcB=10 and ALUop=00, then go to ADDIWB.
REQ-024 The ADDIWB state (10) SHALL drive RegWrite=1, then go to FETCH.
REQ-025 The JUMP state (11) SHALL drive PCSrc=10 and PCWrite=1, then go to FETCH.
REQ-026 Unused encodings 12-15 SHALL go to FETCH on the next edge, with all enables 0 while in them.
REQ-027 The block SHALL have zero cycles of latency from state to outputs.
REQ-028 Instruction cycle counts SHALL be, with zero wait states:
- lw: 5
- sw, R-type, addi: 4
- beq, j: 3
- illegal: 2
Each wait-state cycle SHALL add one.
REQ-029 op SHALL be sampled only in DECODE and MEMADR; changes to op in any other state SHALL have no effect.

Reset
REQ-030 While rst_n is low at a rising edge, state SHALL load FETCH, aborting any in-flight instruction, including a pending MEMWR or MEMRD wait.
REQ-031 While rst_n is low, PCWrite, IRWrite, RegWrite and MemWrite SHALL be forced to 0, regardless of state or mem_ready.
REQ-032 In the first cycle after reset releases, outputs SHALL equal the FETCH decode.

Structure
REQ-033 A shared package SHALL hold the state encoding constants, opcode constants and ALUop constants (ADD=00, SUB=01, FUNCT=10); the ALU-control decoder shares the ALUop constants.
REQ-034 One sub-module, multicycle_outdec, SHALL map state and mem_ready to the control word combinationally; next-state logic and the state register SHALL stay in multicycle_control.

Verification
REQ-035 The bench SHALL cover a reset: hold rst_n=0 for 2 cycles with mem_ready=1 -> state=0, all write enables 0 throughout, then PCWrite=IRWrite=1 in the first cycle after release.
REQ-036 The bench SHALL cover lw with zero wait states: mem_ready=1 constantly, op=100011 -> states 0,1,2,3,4,0; RegWrite=1 only in state 4, with MemtoReg=1.
REQ-037 The bench SHALL cover sw with 3 wait states: op=101011, mem_ready low 3 cycles in MEMWR -> MemWrite=1 for 4 cycles, then state=0.
REQ-038 The bench SHALL cover R-type: op=000000 -> ALUop=10 exactly in state 6; RegDst=RegWrite=1 in state 7; 4 cycles total.
REQ-039 The bench SHALL cover an illegal opcode: op=111111 -> illegal_op=1 for one cycle in state 1, next state 0, no enable asserted.
REQ-040 The bench SHALL cover reset mid-wait: rst_n=0 during MEMRD with mem_ready=0 -> state=0 at the next edge, RegWrite never asserted.
